// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM states,
// PC reset/step constants and the saturating-counter helper.
package pc_pkg;

    // Sequencer states: settle after reset, normal fetch, memory stall
    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_RESET_VALUE = 32'h0000_0000;
    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [15:0] COUNT_MAX      = 16'hFFFF;

    // Increment that sticks at COUNT_MAX instead of wrapping to zero
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == COUNT_MAX) begin
            result = COUNT_MAX;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage : pc_pkg

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the control-flow logic and the PC sequencer.
// The master side supplies the flow decision, offset and memory stall; the
// slave side (the sequencer) returns the PC, run status and counters.
interface pc_sequencer_if;

    logic        FLOW_SELECT;
    logic [7:0]  OFFSET;
    logic        BUSYWAIT;
    logic [31:0] PC;
    logic        RUNNING;
    logic [15:0] INSTR_COUNT;
    logic [15:0] STALL_COUNT;

    modport master (
        output FLOW_SELECT,
        output OFFSET,
        output BUSYWAIT,
        input  PC,
        input  RUNNING,
        input  INSTR_COUNT,
        input  STALL_COUNT
    );

    modport slave (
        input  FLOW_SELECT,
        input  OFFSET,
        input  BUSYWAIT,
        output PC,
        output RUNNING,
        output INSTR_COUNT,
        output STALL_COUNT
    );

endinterface : pc_sequencer_if

// File: rtl/pc_sequencer_branch_target_adder.sv
// Combinational address generation: sequential successor (PC + 4) and the
// PC-relative branch target (PC + 4 + sign-extended word offset * 4).
// All arithmetic is modulo 2^32; wrap-around is intentional and silent.
module branch_target_adder
    import pc_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [7:0]  OFFSET,
    output logic [31:0] PC_PLUS4,
    output logic [31:0] TARGET
);

    logic [31:0] byte_offset;

    // Sign-extend the word offset and convert it to a byte offset
    always_comb begin
        byte_offset = {{22{OFFSET[7]}}, OFFSET, 2'b00};
    end

    // Sequential successor and relative target share the PC + 4 base
    always_comb begin
        PC_PLUS4 = PC + PC_STEP;
        TARGET   = PC_PLUS4 + byte_offset;
    end

endmodule : branch_target_adder

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the 8-bit single-cycle processor.
// Owns the 32-bit PC register, selects between sequential fetch and the
// branch target, holds during memory stalls, inserts one settle cycle after
// reset and keeps saturating retired-instruction / stall-cycle counters.
// Every output is taken straight from a register, so no input reaches an
// output combinationally.
module pc_sequencer
    import pc_pkg::*;
(
    input  logic           CLK,
    input  logic           RESET,
    pc_sequencer_if.slave  bus
);

    pc_state_t   state_q;
    pc_state_t   state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [15:0] instr_count_q;
    logic [15:0] instr_count_d;
    logic [15:0] stall_count_q;
    logic [15:0] stall_count_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] next_pc;

    branch_target_adder u_branch_target_adder (
        .PC       (pc_q),
        .OFFSET   (bus.OFFSET),
        .PC_PLUS4 (pc_plus4),
        .TARGET   (target)
    );

    // Next-PC mux: decision is taken from the releasing cycle, nothing is
    // captured at stall entry
    always_comb begin
        next_pc = bus.FLOW_SELECT ? target : pc_plus4;
    end

    // FSM next-state, PC and counter update rules
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_count_d = instr_count_q;
        stall_count_d = stall_count_q;
        case (state_q)
            S_RESET: begin
                // Settle cycle: inputs ignored, everything holds
                state_d = S_RUN;
            end
            S_RUN, S_STALL: begin
                if (bus.BUSYWAIT) begin
                    state_d       = S_STALL;
                    stall_count_d = sat_inc(stall_count_q);
                end else begin
                    state_d       = S_RUN;
                    pc_d          = next_pc;
                    instr_count_d = sat_inc(instr_count_q);
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // State, PC and counter registers with synchronous active-high reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_RESET;
            pc_q          <= PC_RESET_VALUE;
            instr_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_count_q <= instr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Registered outputs; RUNNING decodes the state register only
    always_comb begin
        bus.PC          = pc_q;
        bus.RUNNING     = (state_q == S_RUN);
        bus.INSTR_COUNT = instr_count_q;
        bus.STALL_COUNT = stall_count_q;
    end

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with fixed
// expected values plus a randomized run against a behavioural model.
module tb_pc_sequencer;

    logic clk;
    logic reset;

    pc_sequencer_if bus ();

    pc_sequencer dut (
        .CLK   (clk),
        .RESET (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_errors;

    // Behavioural model: architectural values plus "cycles since reset"
    logic [31:0] m_pc;
    int          m_instr;
    int          m_stall;
    int          m_since_reset;
    bit          m_running;

    // Drive one cycle of stimulus, clock it, advance the model, then settle
    task automatic step(input logic r, input logic fs, input logic [7:0] off, input logic bw);
        int delta;
        @(negedge clk);
        reset           = r;
        bus.FLOW_SELECT = fs;
        bus.OFFSET      = off;
        bus.BUSYWAIT    = bw;
        @(posedge clk);
        if (r) begin
            m_pc          = 32'h0;
            m_instr       = 0;
            m_stall       = 0;
            m_since_reset = 0;
            m_running     = 1'b0;
        end else if (m_since_reset == 0) begin
            m_since_reset = 1;
            m_running     = 1'b1;
        end else if (bw) begin
            if (m_stall < 65535) m_stall++;
            m_running = 1'b0;
        end else begin
            delta = fs ? 4 + 4 * int'($signed(off)) : 4;
            m_pc  = m_pc + 32'(delta);
            if (m_instr < 65535) m_instr++;
            m_running = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        n_checks++;
        if (bus.PC !== 32'h0 || bus.RUNNING !== 1'b0 || bus.INSTR_COUNT !== 16'h0 || bus.STALL_COUNT !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_state: got pc=%h run=%b ic=%h sc=%h, expected pc=0 run=0 ic=0 sc=0",
                     bus.PC, bus.RUNNING, bus.INSTR_COUNT, bus.STALL_COUNT);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 8'h00, 0);
            n_checks++;
            if (bus.PC !== exp_pc[i] || bus.RUNNING !== 1'b1) begin
                n_errors++;
                $display("FAIL run_edge%0d: got pc=%h run=%b, expected pc=%h run=1",
                         i + 1, bus.PC, bus.RUNNING, exp_pc[i]);
            end
        end
        n_checks++;
        if (bus.INSTR_COUNT !== 16'd3) begin
            n_errors++;
            $display("FAIL run_instr_count: got %0d expected 3", bus.INSTR_COUNT);
        end
    endtask

    task automatic test_branch();
        step(0, 0, 8'h00, 0);
        n_checks++;
        if (bus.PC !== 32'h10) begin
            n_errors++;
            $display("FAIL branch_setup: got %h expected 00000010", bus.PC);
        end
        step(0, 1, 8'h03, 0);
        n_checks++;
        if (bus.PC !== 32'h20) begin
            n_errors++;
            $display("FAIL branch_forward: got %h expected 00000020", bus.PC);
        end
        step(0, 1, 8'hFE, 0);
        n_checks++;
        if (bus.PC !== 32'h1C) begin
            n_errors++;
            $display("FAIL branch_backward: got %h expected 0000001c", bus.PC);
        end
        step(0, 1, 8'h00, 0);
        n_checks++;
        if (bus.PC !== 32'h20) begin
            n_errors++;
            $display("FAIL branch_zero_offset: got %h expected 00000020", bus.PC);
        end
    endtask

    task automatic test_stall();
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h01, 1);
        n_checks++;
        if (bus.PC !== 32'h08 || bus.STALL_COUNT !== 16'd3 || bus.RUNNING !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_hold: got pc=%h sc=%0d run=%b, expected pc=00000008 sc=3 run=0",
                     bus.PC, bus.STALL_COUNT, bus.RUNNING);
        end
        step(0, 1, 8'h01, 0);
        n_checks++;
        if (bus.PC !== 32'h10 || bus.INSTR_COUNT !== 16'd3 || bus.RUNNING !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_release: got pc=%h ic=%0d run=%b, expected pc=00000010 ic=3 run=1",
                     bus.PC, bus.INSTR_COUNT, bus.RUNNING);
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'hFE, 0);
        n_checks++;
        if (bus.PC !== 32'hFFFF_FFFC) begin
            n_errors++;
            $display("FAIL wrap_backward_below_zero: got %h expected fffffffc", bus.PC);
        end
        step(0, 0, 8'h00, 0);
        n_checks++;
        if (bus.PC !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_sequential: got %h expected 00000000", bus.PC);
        end
        step(0, 1, 8'hFF, 0);
        n_checks++;
        if (bus.PC !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_offset_minus1: got %h expected 00000000", bus.PC);
        end
    endtask

    task automatic test_reset_mid_stall();
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        step(0, 1, 8'h0F, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1);
        n_checks++;
        if (bus.PC !== 32'h40 || bus.STALL_COUNT !== 16'd5) begin
            n_errors++;
            $display("FAIL midstall_setup: got pc=%h sc=%0d, expected pc=00000040 sc=5",
                     bus.PC, bus.STALL_COUNT);
        end
        step(1, 0, 8'h00, 1);
        n_checks++;
        if (bus.PC !== 32'h0 || bus.INSTR_COUNT !== 16'h0 || bus.STALL_COUNT !== 16'h0 || bus.RUNNING !== 1'b0) begin
            n_errors++;
            $display("FAIL midstall_reset: got pc=%h ic=%0d sc=%0d run=%b, expected all zero",
                     bus.PC, bus.INSTR_COUNT, bus.STALL_COUNT, bus.RUNNING);
        end
        step(0, 1, 8'h05, 1);
        n_checks++;
        if (bus.PC !== 32'h0 || bus.INSTR_COUNT !== 16'h0 || bus.STALL_COUNT !== 16'h0 || bus.RUNNING !== 1'b1) begin
            n_errors++;
            $display("FAIL midstall_settle: got pc=%h ic=%0d sc=%0d run=%b, expected pc=0 ic=0 sc=0 run=1",
                     bus.PC, bus.INSTR_COUNT, bus.STALL_COUNT, bus.RUNNING);
        end
    endtask

    task automatic test_saturation();
        step(1, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        for (int i = 0; i < 65534; i++) step(0, 0, 8'h00, 1);
        n_checks++;
        if (bus.STALL_COUNT !== 16'hFFFE) begin
            n_errors++;
            $display("FAIL sat_preload: got %h expected fffe", bus.STALL_COUNT);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'h00, 1);
            n_checks++;
            if (bus.STALL_COUNT !== 16'hFFFF) begin
                n_errors++;
                $display("FAIL sat_hold%0d: got %h expected ffff", i, bus.STALL_COUNT);
            end
        end
        n_checks++;
        if (bus.PC !== 32'h0 || bus.INSTR_COUNT !== 16'h0) begin
            n_errors++;
            $display("FAIL sat_pc_held: got pc=%h ic=%0d expected pc=0 ic=0", bus.PC, bus.INSTR_COUNT);
        end
    endtask

    task automatic test_random();
        logic       r;
        logic       fs;
        logic [7:0] off;
        logic       bw;
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 49) == 0);
            fs  = 1'($urandom_range(0, 1));
            off = 8'($urandom);
            bw  = ($urandom_range(0, 9) < 3);
            step(r, fs, off, bw);
            n_checks++;
            if (bus.PC !== m_pc || bus.RUNNING !== m_running ||
                bus.INSTR_COUNT !== 16'(m_instr) || bus.STALL_COUNT !== 16'(m_stall)) begin
                n_errors++;
                $display("FAIL random_step%0d: got pc=%h run=%b ic=%0d sc=%0d, expected pc=%h run=%b ic=%0d sc=%0d",
                         i, bus.PC, bus.RUNNING, bus.INSTR_COUNT, bus.STALL_COUNT,
                         m_pc, m_running, m_instr, m_stall);
            end
        end
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        m_pc            = 32'h0;
        m_instr         = 0;
        m_stall         = 0;
        m_since_reset   = 0;
        m_running       = 1'b0;
        reset           = 1'b1;
        bus.FLOW_SELECT = 1'b0;
        bus.OFFSET      = 8'h00;
        bus.BUSYWAIT    = 1'b0;

        test_reset();
        test_branch();
        test_stall();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        test_saturation();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pc_sequencer
